// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: turns hazards, redirects and memory readiness into per-stage pipeline strobes
module pipe_hazard_ctrl #(
   parameter int unsigned WAIT_MAX = 15,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic             mem_redirect,
   input  logic             mem_cs_n,
   input  logic             dmem_ready,
   input  logic             imem_ready,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             pipe_freeze,
   output logic             dmem_abort,
   output logic             err_timeout,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef enum logic [1:0] {RUN, DWAIT, ABORT} state_t;
   localparam logic [7:0] WMAX = 8'(WAIT_MAX);
   state_t state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic err_q;
   logic [CNT_W-1:0] cnt_q;
   logic load_use, adv_pc, adv_iff;
   assign load_use = ex_memread && ex_rd != 5'd0 &&
                     ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
   assign adv_pc  = !load_use && imem_ready;
   assign adv_iff = !load_use && !imem_ready;
   assign ifid_we     = pc_we;
   assign err_timeout = err_q;
   assign stall_cnt   = cnt_q;
   // next state and strobes; a load-use bubble takes precedence over an imem miss bubble
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      pc_we       = adv_pc;
      ifid_flush  = adv_iff;
      idex_flush  = load_use;
      exmem_flush = 1'b0;
      pipe_freeze = 1'b0;
      dmem_abort  = 1'b0;
      case (state_q)
         RUN: begin
            if (mem_redirect) begin
               pc_we       = 1'b1;
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
            end else if (!mem_cs_n && !dmem_ready) begin
               pc_we       = 1'b0;
               ifid_flush  = 1'b0;
               idex_flush  = 1'b0;
               pipe_freeze = 1'b1;
               state_d     = DWAIT;
               wait_d      = 8'd1;
            end
         end
         DWAIT: begin
            if (dmem_ready) begin
               state_d = RUN;
               wait_d  = 8'd0;
            end else begin
               pc_we       = 1'b0;
               ifid_flush  = 1'b0;
               idex_flush  = 1'b0;
               pipe_freeze = 1'b1;
               state_d     = wait_q == WMAX ? ABORT : DWAIT;
               wait_d      = wait_q == WMAX ? wait_q : wait_q + 8'd1;
            end
         end
         ABORT: begin
            dmem_abort = 1'b1;
            state_d    = RUN;
            wait_d     = 8'd0;
         end
         default: begin
            state_d = RUN;
            wait_d  = 8'd0;
         end
      endcase
      if (!rst_n) begin
         pc_we       = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         pipe_freeze = 1'b0;
         dmem_abort  = 1'b0;
      end
   end
   // FSM, sticky timeout flag and saturating stall counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         wait_q  <= 8'd0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_q || state_q == ABORT;
         if (!pc_we && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks against a cycle-level behavioural model
module tb_pipe_hazard_ctrl;
   localparam int WM = 15;
   localparam int CW = 6;
   localparam int CMAX = (1 << CW) - 1;
   logic clk = 1'b0;
   logic rst_n, id_use_rs1, id_use_rs2, ex_memread, mem_redirect, mem_cs_n, dmem_ready, imem_ready;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_freeze, dmem_abort, err_timeout;
   logic [CW-1:0] stall_cnt;
   int checks = 0;
   int failures = 0;
   int m_wait = 0;
   bit m_abort = 0;
   bit m_err = 0;
   int m_stall = 0;
   logic o_pc, o_ifwe, o_iff, o_idf, o_exf, o_frz, o_ab, o_err;
   logic [CW-1:0] o_cnt;
   int frz, s0, stuck;

   pipe_hazard_ctrl #(.WAIT_MAX(WM), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
      .mem_redirect(mem_redirect), .mem_cs_n(mem_cs_n), .dmem_ready(dmem_ready),
      .imem_ready(imem_ready), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exmem_flush(exmem_flush), .pipe_freeze(pipe_freeze),
      .dmem_abort(dmem_abort), .err_timeout(err_timeout), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      rst_n = 1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_memread = 0; ex_rd = 0;
      mem_redirect = 0; mem_cs_n = 1; dmem_ready = 1; imem_ready = 1;
   endtask

   // one clock cycle: compare against the model at negedge, advance the model, move past posedge
   task automatic step();
      bit lu, e_pc, e_iff, e_idf, e_exf, e_frz, e_ab;
      @(negedge clk);
      lu = ex_memread && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      e_pc = !lu && imem_ready; e_iff = !lu && !imem_ready; e_idf = lu; e_exf = 0; e_frz = 0; e_ab = 0;
      if (!rst_n) begin
         e_pc = 0; e_iff = 1; e_idf = 1; e_exf = 1;
      end else if (m_abort) begin
         e_ab = 1;
      end else if (m_wait > 0 ? !dmem_ready : (!mem_redirect && !mem_cs_n && !dmem_ready)) begin
         e_pc = 0; e_iff = 0; e_idf = 0; e_frz = 1;
      end else if (m_wait == 0 && mem_redirect) begin
         e_pc = 1; e_iff = 1; e_idf = 1; e_exf = 1;
      end
      o_pc = pc_we; o_ifwe = ifid_we; o_iff = ifid_flush; o_idf = idex_flush; o_exf = exmem_flush;
      o_frz = pipe_freeze; o_ab = dmem_abort; o_err = err_timeout; o_cnt = stall_cnt;
      chk("pc_we", 32'(o_pc), 32'(e_pc));
      chk("ifid_we", 32'(o_ifwe), 32'(e_pc));
      chk("ifid_flush", 32'(o_iff), 32'(e_iff));
      chk("idex_flush", 32'(o_idf), 32'(e_idf));
      chk("exmem_flush", 32'(o_exf), 32'(e_exf));
      chk("pipe_freeze", 32'(o_frz), 32'(e_frz));
      chk("dmem_abort", 32'(o_ab), 32'(e_ab));
      chk("err_timeout", 32'(o_err), 32'(m_err));
      chk("stall_cnt", 32'(o_cnt), 32'(m_stall));
      if (!rst_n) begin
         m_wait = 0; m_abort = 0; m_err = 0; m_stall = 0;
      end else begin
         if (!e_pc && m_stall < CMAX) m_stall++;
         if (m_abort) begin
            m_err = 1; m_abort = 0;
         end else if (m_wait > 0) begin
            if (dmem_ready) m_wait = 0;
            else if (m_wait == WM) begin m_wait = 0; m_abort = 1; end
            else m_wait++;
         end else if (!mem_redirect && !mem_cs_n && !dmem_ready) m_wait = 1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      step();
      chk("rst_state", {o_pc, o_ifwe, o_iff, o_idf, o_exf, o_frz, o_ab}, 7'b0011100);
      idle(); ex_memread = 1; ex_rd = 5; id_use_rs2 = 1; id_rs2 = 5;
      step();
      chk("lu_stall", {o_pc, o_ifwe, o_idf, o_iff}, 4'b0010);
      ex_memread = 0;
      step();
      chk("lu_release", 32'(o_pc), 1);
      idle(); ex_memread = 1; ex_rd = 0; id_use_rs1 = 1; id_rs1 = 0;
      step();
      chk("x0_no_stall", 32'(o_pc), 1);
      idle(); mem_redirect = 1; mem_cs_n = 1;
      step();
      chk("redirect", {o_pc, o_iff, o_idf, o_exf}, 4'hf);
      idle();
      step();
      s0 = int'(o_cnt);
      mem_cs_n = 0; dmem_ready = 0; frz = 0;
      repeat (3) begin step(); frz += int'(o_frz); end
      dmem_ready = 1;
      step();
      chk("store_freeze", 32'(frz), 3);
      chk("store_release", {o_frz, o_pc}, 2'b01);
      idle();
      step();
      chk("store_stalls", 32'(o_cnt), 32'(s0 + 3));
      mem_cs_n = 0; dmem_ready = 0; frz = 0;
      repeat (16) begin step(); frz += int'(o_frz); end
      chk("timeout_freeze", 32'(frz), 16);
      step();
      chk("timeout_abort", {o_ab, o_frz, o_err}, 3'b100);
      idle();
      step();
      chk("timeout_err", {o_ab, o_err}, 2'b01);
      mem_cs_n = 0; dmem_ready = 0;
      repeat (2) step();
      rst_n = 0;
      step();
      chk("rst_mid_wait", {o_pc, o_ifwe, o_iff, o_idf, o_exf, o_frz}, 6'b001110);
      idle();
      step();
      chk("rst_clears", {o_err, o_frz, 1'b0}, 3'b000);
      chk("rst_cnt", 32'(o_cnt), 0);
      stuck = 0;
      for (int i = 0; i < 3000; i++) begin
         rst_n = $urandom_range(0, 99) != 0;
         id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
         ex_rd = 5'($urandom_range(0, 3));
         id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
         ex_memread = 1'($urandom_range(0, 1));
         mem_redirect = $urandom_range(0, 7) == 0;
         mem_cs_n = $urandom_range(0, 2) != 0;
         imem_ready = $urandom_range(0, 3) != 0;
         if (stuck == 0 && $urandom_range(0, 49) == 0) stuck = 20;
         dmem_ready = stuck > 0 ? 1'b0 : 1'($urandom_range(0, 1));
         if (stuck > 0) stuck--;
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
